// File: rtl/conv_fifo_scheduler_pkg.sv
// Shared constants for the convolution line-buffer scheduler: default widths and FSM encoding.
package conv_fifo_scheduler_pkg;

    localparam int unsigned DefDataWidth   = 32;
    localparam int unsigned DefBufferWidth = 4;
    localparam int unsigned DefBufferSize  = 16;
    localparam int unsigned DefFillThresh  = 9;
    localparam int unsigned DefCntWidth    = 16;

    localparam int unsigned StateWidth = 3;

    localparam logic [StateWidth-1:0] StIdle  = 3'd0;
    localparam logic [StateWidth-1:0] StFill  = 3'd1;
    localparam logic [StateWidth-1:0] StRun   = 3'd2;
    localparam logic [StateWidth-1:0] StDrain = 3'd3;
    localparam logic [StateWidth-1:0] StDone  = 3'd4;

    // States in which upstream words may be accepted.
    function automatic logic is_streaming(input logic [StateWidth-1:0] st);
        return (st == StFill) || (st == StRun);
    endfunction

endpackage

// File: rtl/conv_fifo_scheduler.sv
// Push/pop sequencer for one line-buffer FIFO: fills to a window depth, streams, drains per frame.
module conv_fifo_scheduler
    import conv_fifo_scheduler_pkg::*;
#(
    parameter int unsigned DataWidth   = DefDataWidth,
    parameter int unsigned BufferWidth = DefBufferWidth,
    parameter int unsigned BufferSize  = DefBufferSize,
    parameter int unsigned FillThresh  = DefFillThresh,
    parameter int unsigned CntWidth    = DefCntWidth
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 Start,
    input  logic [CntWidth-1:0]  FrameLen,
    input  logic                 In_Valid,
    input  logic [DataWidth-1:0] In_Data,
    output logic                 In_Ready,
    output logic                 Fifo_Push,
    output logic [DataWidth-1:0] Fifo_DataIn,
    output logic                 Fifo_Pop,
    input  logic                 Fifo_Full,
    input  logic [DataWidth-1:0] Fifo_DataOut,
    output logic                 Out_Valid,
    output logic [DataWidth-1:0] Out_Data,
    input  logic                 Out_Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err
);

    localparam int unsigned OccWidth = BufferWidth + 1;

    localparam logic [OccWidth-1:0] OccFull   = OccWidth'(BufferSize);
    localparam logic [OccWidth-1:0] OccThresh = OccWidth'(FillThresh);
    localparam logic [OccWidth-1:0] OccOne    = OccWidth'(1);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

    logic [StateWidth-1:0] state_q, state_d;
    logic [OccWidth-1:0]   occ_q, occ_d;
    logic [CntWidth-1:0]   in_cnt_q, in_cnt_d;
    logic [CntWidth-1:0]   out_cnt_q, out_cnt_d;
    logic [CntWidth-1:0]   frame_len_q, frame_len_d;
    logic                  pend_q, pend_d;
    logic                  out_valid_q, out_valid_d;
    logic [DataWidth-1:0]  out_data_q, out_data_d;
    logic                  err_q, err_d;

    logic                  in_ready;
    logic                  push;
    logic                  pop;
    logic                  pop_gate;
    logic                  slot_free;
    logic                  load;
    logic                  deliver;
    logic                  in_done;
    logic [CntWidth-1:0]   in_cnt_next;
    logic [CntWidth-1:0]   out_cnt_next;

    // Handshake and FIFO control
    always_comb begin
        in_done   = (in_cnt_q == frame_len_q);
        in_ready  = is_streaming(state_q) && (occ_q < OccFull) && (in_cnt_q < frame_len_q);
        push      = In_Valid && in_ready;
        slot_free = !out_valid_q || Out_Ready;
        deliver   = out_valid_q && Out_Ready;

        pop_gate = 1'b0;
        case (state_q)
            StRun:   pop_gate = (occ_q >= OccThresh) || in_done;
            StDrain: pop_gate = 1'b1;
            default: pop_gate = 1'b0;
        endcase
        pop = slot_free && (occ_q != '0) && pop_gate;

        // The FIFO read port holds its word between pops, so a popped word that cannot
        // enter the output register yet simply waits there.
        load = pend_q && slot_free;

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OccOne;
            2'b01:   occ_d = occ_q - OccOne;
            default: occ_d = occ_q;
        endcase

        in_cnt_next  = push ? (in_cnt_q + CntOne) : in_cnt_q;
        out_cnt_next = deliver ? (out_cnt_q + CntOne) : out_cnt_q;
    end

    // Output register
    always_comb begin
        pend_d      = pop || (pend_q && !load);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = Fifo_DataOut;
        end else if (Out_Ready) begin
            out_valid_d = 1'b0;
        end
        err_d = err_q || (Fifo_Full && (occ_q < OccFull));
    end

    // Frame sequencing
    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        in_cnt_d    = in_cnt_next;
        out_cnt_d   = out_cnt_next;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    frame_len_d = FrameLen;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    state_d     = (FrameLen == '0) ? StDone : StFill;
                end
            end
            StFill: begin
                if ((occ_d >= OccThresh) || (in_cnt_next == frame_len_q)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (in_done) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_cnt_next == frame_len_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= StIdle;
            occ_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            frame_len_q <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            frame_len_q <= frame_len_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign In_Ready    = in_ready;
    assign Fifo_Push   = push;
    assign Fifo_DataIn = In_Data;
    assign Fifo_Pop    = pop;
    assign Out_Valid   = out_valid_q;
    assign Out_Data    = out_data_q;
    assign Busy        = (state_q != StIdle);
    assign Done        = (state_q == StDone);
    assign Err         = err_q;

endmodule

// File: tb/tb_conv_fifo_scheduler.sv
// Bench for conv_fifo_scheduler: behavioural FIFO, frame-level scoreboard, directed frames.
module tb_conv_fifo_scheduler;

    logic        clk = 1'b0;
    logic        aclr_n;
    logic        Start;
    logic [15:0] FrameLen;
    logic        In_Valid;
    logic [31:0] In_Data;
    logic        In_Ready;
    logic        Fifo_Push;
    logic [31:0] Fifo_DataIn;
    logic        Fifo_Pop;
    logic        Fifo_Full;
    logic [31:0] Fifo_DataOut;
    logic        Out_Valid;
    logic [31:0] Out_Data;
    logic        Out_Ready;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic        force_full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_fifo_scheduler #(
        .DataWidth   (32),
        .BufferWidth (4),
        .BufferSize  (16),
        .FillThresh  (9),
        .CntWidth    (16)
    ) dut (
        .clk          (clk),
        .aclr_n       (aclr_n),
        .Start        (Start),
        .FrameLen     (FrameLen),
        .In_Valid     (In_Valid),
        .In_Data      (In_Data),
        .In_Ready     (In_Ready),
        .Fifo_Push    (Fifo_Push),
        .Fifo_DataIn  (Fifo_DataIn),
        .Fifo_Pop     (Fifo_Pop),
        .Fifo_Full    (Fifo_Full),
        .Fifo_DataOut (Fifo_DataOut),
        .Out_Valid    (Out_Valid),
        .Out_Data     (Out_Data),
        .Out_Ready    (Out_Ready),
        .Busy         (Busy),
        .Done         (Done),
        .Err          (Err)
    );

    // Behavioural 16-deep FIFO: registered read port that holds between pops.
    logic [31:0] f_mem [16];
    logic [3:0]  f_wr;
    logic [3:0]  f_rd;
    int          f_cnt;
    logic [31:0] f_dout;

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            f_wr   <= '0;
            f_rd   <= '0;
            f_cnt  <= 0;
            f_dout <= '0;
        end else begin
            if (Fifo_Push && f_cnt < 16) begin
                f_mem[f_wr] <= Fifo_DataIn;
                f_wr        <= f_wr + 4'd1;
            end
            if (Fifo_Pop && f_cnt > 0) begin
                f_dout <= f_mem[f_rd];
                f_rd   <= f_rd + 4'd1;
            end
            f_cnt <= f_cnt + ((Fifo_Push && f_cnt < 16) ? 1 : 0) - ((Fifo_Pop && f_cnt > 0) ? 1 : 0);
        end
    end

    assign Fifo_Full    = (f_cnt == 16) || force_full;
    assign Fifo_DataOut = f_dout;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: words accepted are delivered in order; expectations from counts.
    logic        m_busy, m_done, m_err, m_outv, m_pend;
    int          m_len, m_in, m_out, m_occ;
    logic [31:0] exp_q[$];
    logic        e_ready, e_push, e_pop, e_deliver, m_load;

    logic [31:0] deliv_q[$];
    int          done_count;
    logic        seen_pop;
    int          pre_pop_pushes;
    int          cyc;
    int          first_pop_cyc;
    int          first_ov_cyc;

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_outv = 1'b0;
        m_pend = 1'b0;
        m_len  = 0;
        m_in   = 0;
        m_out  = 0;
        m_occ  = 0;
        exp_q.delete();
    endtask

    initial model_reset();

    always @(negedge clk) begin
        cyc++;
        if (!aclr_n) begin
            model_reset();
            check_word("reset_out_data", Out_Data, 32'd0);
        end
        e_ready   = m_busy && !m_done && (m_in < m_len) && (m_occ < 16);
        e_push    = In_Valid && e_ready;
        e_pop     = m_busy && !m_done && (!m_outv || Out_Ready) && (m_occ > 0)
                    && ((m_occ >= 9) || (m_in == m_len));
        e_deliver = m_outv && Out_Ready;

        check_bit("in_ready", In_Ready, e_ready);
        check_bit("fifo_push", Fifo_Push, e_push);
        check_bit("fifo_pop", Fifo_Pop, e_pop);
        check_bit("out_valid", Out_Valid, m_outv);
        check_bit("busy", Busy, m_busy);
        check_bit("done", Done, m_done);
        check_bit("err", Err, m_err);
        if (e_deliver) begin
            if (exp_q.size() > 0) check_word("out_data", Out_Data, exp_q[0]);
            else check_bit("out_data_unexpected", 1'b1, 1'b0);
        end

        if (Out_Valid && Out_Ready) deliv_q.push_back(Out_Data);
        if (Done) done_count++;
        if (Fifo_Pop && !seen_pop) begin
            seen_pop      = 1'b1;
            first_pop_cyc = cyc;
        end
        if (Fifo_Push && !seen_pop) pre_pop_pushes++;
        if (Out_Valid && first_ov_cyc < 0) first_ov_cyc = cyc;

        if (aclr_n) begin
            m_err  = m_err || (Fifo_Full && m_occ < 16);
            m_load = m_pend && (!m_outv || Out_Ready);
            if (e_push) begin
                exp_q.push_back(In_Data);
                m_in++;
                m_occ++;
            end
            if (e_pop) m_occ--;
            if (e_deliver) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_out++;
            end
            m_pend = e_pop || (m_pend && !m_load);
            m_outv = m_load || (m_outv && !Out_Ready);
            if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (!m_busy && Start) begin
                m_busy = 1'b1;
                m_len  = int'(FrameLen);
                m_in   = 0;
                m_out  = 0;
                m_done = (FrameLen == 16'd0);
            end else if (m_busy && e_deliver && m_out == m_len) begin
                m_done = 1'b1;
            end
        end
    end

    task automatic step();
        logic acc;
        @(negedge clk);
        acc = In_Valid && In_Ready;
        @(posedge clk);
        #1;
        if (acc) In_Data = In_Data + 32'd1;
    endtask

    task automatic new_frame_stats();
        deliv_q.delete();
        done_count     = 0;
        seen_pop       = 1'b0;
        pre_pop_pushes = 0;
        first_pop_cyc  = -1;
        first_ov_cyc   = -1;
        In_Data        = 32'd0;
    endtask

    task automatic start_frame(input int len);
        Start    = 1'b1;
        FrameLen = 16'(len);
        step();
        Start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int n = 0;
        while (!Done && n < maxc) begin
            step();
            n++;
        end
        check_bit(name, Done, 1'b1);
        step();
        check_bit({name, "_idle"}, Busy, 1'b0);
    endtask

    task automatic check_deliv(input string name, input int n);
        check_word({name, "_count"}, 32'(deliv_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < deliv_q.size()) check_word({name, "_data"}, deliv_q[i], 32'(i));
        end
    endtask

    initial begin
        cyc        = 0;
        aclr_n     = 1'b0;
        Start      = 1'b0;
        FrameLen   = 16'd0;
        In_Valid   = 1'b0;
        In_Data    = 32'd0;
        Out_Ready  = 1'b0;
        force_full = 1'b0;
        new_frame_stats();
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_busy", Busy, 1'b0);
        check_bit("rst_out_valid", Out_Valid, 1'b0);
        check_bit("rst_in_ready", In_Ready, 1'b0);
        check_bit("rst_err", Err, 1'b0);
        check_bit("rst_done", Done, 1'b0);
        aclr_n = 1'b1;
        step();

        // 1: streaming frame of 20
        new_frame_stats();
        In_Valid  = 1'b1;
        Out_Ready = 1'b1;
        start_frame(20);
        wait_done(200, "t1_done");
        check_word("t1_pushes_before_pop", 32'(pre_pop_pushes), 32'd9);
        check_word("t1_out_latency", 32'(first_ov_cyc - first_pop_cyc), 32'd2);
        check_word("t1_done_count", 32'(done_count), 32'd1);
        check_deliv("t1", 20);

        // 2: downstream stall fills the buffer
        new_frame_stats();
        start_frame(40);
        repeat (15) step();
        Out_Ready = 1'b0;
        repeat (25) step();
        check_word("t2_fifo_full", 32'(f_cnt), 32'd16);
        check_bit("t2_in_ready_full", In_Ready, 1'b0);
        check_bit("t2_no_push_full", Fifo_Push, 1'b0);
        Out_Ready = 1'b1;
        wait_done(200, "t2_done");
        check_deliv("t2", 40);

        // 3: frame shorter than the fill threshold
        new_frame_stats();
        start_frame(5);
        wait_done(100, "t3_done");
        check_deliv("t3", 5);

        // 4: steady push+pop at threshold, Start ignored mid-frame
        new_frame_stats();
        start_frame(30);
        repeat (15) step();
        for (int i = 0; i < 3; i++) begin
            check_word("t4_occ_hold", 32'(f_cnt), 32'd9);
            check_bit("t4_push", Fifo_Push, 1'b1);
            check_bit("t4_pop", Fifo_Pop, 1'b1);
            step();
        end
        start_frame(3);
        wait_done(200, "t4_done");
        check_deliv("t4", 30);

        // 5: asynchronous clear mid-frame, then a fresh frame
        new_frame_stats();
        start_frame(30);
        repeat (14) step();
        aclr_n = 1'b0;
        #1;
        check_bit("t5_busy", Busy, 1'b0);
        check_bit("t5_out_valid", Out_Valid, 1'b0);
        check_bit("t5_in_ready", In_Ready, 1'b0);
        check_bit("t5_push", Fifo_Push, 1'b0);
        check_bit("t5_pop", Fifo_Pop, 1'b0);
        check_word("t5_out_data", Out_Data, 32'd0);
        step();
        aclr_n = 1'b1;
        step();
        new_frame_stats();
        start_frame(8);
        wait_done(100, "t5_done");
        check_deliv("t5", 8);

        // 6: spurious Full sets sticky Err; empty frame completes at once
        new_frame_stats();
        start_frame(20);
        begin
            int n = 0;
            while (f_cnt != 3 && n < 20) begin
                step();
                n++;
            end
        end
        check_word("t6_occ3", 32'(f_cnt), 32'd3);
        force_full = 1'b1;
        step();
        force_full = 1'b0;
        check_bit("t6_err_set", Err, 1'b1);
        wait_done(200, "t6_done");
        check_bit("t6_err_sticky", Err, 1'b1);
        start_frame(0);
        check_bit("t6_len0_done", Done, 1'b1);
        step();
        check_bit("t6_len0_done_clear", Done, 1'b0);
        check_bit("t6_len0_idle", Busy, 1'b0);
        check_bit("t6_err_still", Err, 1'b1);
        aclr_n = 1'b0;
        #1;
        check_bit("t6_err_reset", Err, 1'b0);
        step();
        aclr_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
